stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
Run/pause/clear/lap controller for the seconds-counting display chain: CLOCK_50 prescaler, BCD digit counters, and four BCDto7 decoders driving HEX3..HEX0.
Takes raw active-low KEY pushbuttons, sequences a 3-state FSM, and generates a 1 Hz tick enable. The tick enable replaces the derived CLOCK_1, so everything runs on a single clock.
Maintains an MM:SS count (00:00..59:59). Presents live or lap-frozen BCD digits to the top-level decoders.

Parameters:
TICK_DIV, 50000000, clk cycles per count tick; legal range 2..2^TICK_W
TICK_W, 26, prescaler counter width

Ports:
clk  in  1  system clock (CLOCK_50)
reset  in  1  asynchronous, active-low reset
start_stop_n  in  1  raw KEY, active-low, asynchronous to clk
clear_n  in  1  raw KEY, active-low, asynchronous to clk
lap_n  in  1  raw KEY, active-low, asynchronous to clk
disp0  out  4  seconds units BCD to decoder (live or frozen)
disp1  out  4  seconds tens BCD, 0..5
disp2  out  4  minutes units BCD
disp3  out  4  minutes tens BCD, 0..5
running  out  1  high in RUN
frozen  out  1  high while lap display hold is active
tick  out  1  one-cycle count-enable pulse (GPIO monitor)
wrap  out  1  one-cycle pulse on 59:59 -> 00:00

Behaviour:
- Reset (async, active-low): state=IDLE; prescaler=0; all digits, snapshot and outputs=0; key sync flops=0. Outputs are zero without any clk edge.
- Key inputs: 2-flop synchronizer plus a previous-value flop per key.
  - press = sync2==0 && prev==1, a one-cycle pulse.
  - The press pulse is visible 3 clk edges after the input falls; one press per high-to-low transition.
  - No debouncing.
  - Sync flops reset to 0, so a key held through reset generates no press.
- FSM states: IDLE=0, RUN=1, PAUSE=2. Encoding 3 is unreachable and returns to IDLE.
  - IDLE: start_stop -> RUN. clear -> IDLE (counters re-zeroed). Both in the same cycle -> IDLE (clear wins).
  - RUN: start_stop -> PAUSE. clear is ignored.
  - PAUSE: start_stop -> RUN. clear -> IDLE. Both in the same cycle -> IDLE (clear wins).
  - Entering IDLE zeroes the digits, prescaler, snapshot and frozen.
- Prescaler:
  - Increments only in RUN; holds its value in PAUSE; cleared in IDLE.
  - When prescaler==TICK_DIV-1 in RUN it wraps to 0 and tick is registered high for exactly one cycle.
- Digits:
  - Update on the clk edge where tick==1, one cycle after the tick rises.
  - A tick already high when the FSM leaves RUN is still applied.
  - Latency from the first RUN cycle to disp0=1 is TICK_DIV+1 cycles.
- Cascade:
  - d0 9->0 carries into d1.
  - d1 5->0 carries into d2.
  - d2 9->0 carries into d3.
  - d3 5->0 (59:59 -> 00:00).
  - wrap is registered high on the same edge the digits become 00:00.
- Lap:
  - In RUN, lap with frozen=0 loads the snapshot from the current digits and sets frozen=1.
  - In RUN, lap with frozen=1 clears frozen.
  - In PAUSE, lap clears frozen. In IDLE, lap is ignored.
  - Counting continues while frozen.
- Display: disp* = frozen ? snapshot : live digits, registered with no extra latency beyond the digit registers.
- Reset asserted mid-operation aborts immediately; there is no partial-count retention.

Decomposition:
- Shared package stopwatch_pkg:
  - state encodings ST_IDLE/ST_RUN/ST_PAUSE
  - DIG_MAX_UNITS=9, DIG_MAX_TENS=5
  - BCD width 4
- One sub-module, key_press_detect:
  - ports: clk, reset, key_n, press
  - implements the 2-flop sync and falling-edge detect
  - instantiated 3 times
- FSM, prescaler, BCD cascade and lap logic stay in stopwatch_ctrl.
- The top level instantiates stopwatch_ctrl plus four BCDto7.

Test Plan:
- Sim parameter TICK_DIV=4 throughout.
- Reset, pulse start_stop_n low for 5 cycles -> running=1 exactly 3 edges after the fall; tick has a 4-cycle period and 1-cycle width; disp0=1 five cycles after RUN entry; exactly one press counted.
- Run 60 ticks -> disp3..0=0,1,0,0. Run 3600 ticks total -> wrap pulses once for 1 cycle, all digits 0, running still 1.
- Pause at disp0=3 with prescaler=2, idle 100 cycles -> digits and prescaler unchanged, tick=0. Resume -> next tick 2 cycles after RUN re-entry.
- In RUN at 00:07, press lap -> frozen=1 and disp shows 00:07 while live reaches 00:12. Press lap again -> disp=00:12 on the next cycle.
- Press clear in RUN -> ignored. Pause, then press clear_n and start_stop_n on the same cycle -> IDLE with all digits 0, running=0, frozen=0.
- Assert reset mid-RUN between clk edges -> all outputs 0 immediately. Hold start_stop_n low across reset release -> FSM stays IDLE.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared encodings and digit limits for the MM:SS stopwatch controller.
package stopwatch_pkg;

    localparam int unsigned BCD_W = 4;

    localparam logic [BCD_W-1:0] DIG_MAX_UNITS = 4'd9;
    localparam logic [BCD_W-1:0] DIG_MAX_TENS  = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_e;

    // Digit order: [0] seconds units, [1] seconds tens, [2] minutes units, [3] minutes tens.
    typedef logic [3:0][BCD_W-1:0] mmss_t;

endpackage

// File: rtl/key_press_detect.sv
// Two-flop synchronizer plus falling-edge detect for one raw active-low pushbutton.
module key_press_detect (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    logic sync1_q, sync2_q, prev_q;

    // Flops reset low so a key held down through reset never looks like a fresh press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign press = ~sync2_q & prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear/lap controller: key sequencing FSM, 1 Hz tick prescaler, MM:SS BCD
// cascade and lap-freeze display mux, all on the single system clock.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned TICK_W   = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_stop_n,
    input  logic             clear_n,
    input  logic             lap_n,
    output logic [BCD_W-1:0] disp0,
    output logic [BCD_W-1:0] disp1,
    output logic [BCD_W-1:0] disp2,
    output logic [BCD_W-1:0] disp3,
    output logic             running,
    output logic             frozen,
    output logic             tick,
    output logic             wrap
);

    localparam logic [TICK_W-1:0] PRESC_LAST = TICK_W'(TICK_DIV - 1);

    logic start_press, clear_press, lap_press;

    sw_state_e         state_q, state_d;
    logic [TICK_W-1:0] presc_q, presc_d;
    logic              tick_q, tick_d;
    logic              wrap_q, wrap_d;
    logic              frozen_q, frozen_d;
    mmss_t             dig_q, dig_d;
    mmss_t             snap_q, snap_d;

    key_press_detect u_key_start (
        .clk   (clk),
        .reset (reset),
        .key_n (start_stop_n),
        .press (start_press)
    );

    key_press_detect u_key_clear (
        .clk   (clk),
        .reset (reset),
        .key_n (clear_n),
        .press (clear_press)
    );

    key_press_detect u_key_lap (
        .clk   (clk),
        .reset (reset),
        .key_n (lap_n),
        .press (lap_press)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_press && !clear_press) state_d = ST_RUN;
            ST_RUN:   if (start_press) state_d = ST_PAUSE;
            ST_PAUSE: begin
                if (clear_press) begin
                    state_d = ST_IDLE;
                end else if (start_press) begin
                    state_d = ST_RUN;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        presc_d  = presc_q;
        tick_d   = 1'b0;
        dig_d    = dig_q;
        wrap_d   = 1'b0;
        frozen_d = frozen_q;
        snap_d   = snap_q;

        if (state_q == ST_RUN) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        // Applied on tick_q regardless of state, so a tick raised on the last RUN edge still counts.
        if (tick_q) begin
            if (dig_q[0] != DIG_MAX_UNITS) begin
                dig_d[0] = dig_q[0] + 1'b1;
            end else begin
                dig_d[0] = '0;
                if (dig_q[1] != DIG_MAX_TENS) begin
                    dig_d[1] = dig_q[1] + 1'b1;
                end else begin
                    dig_d[1] = '0;
                    if (dig_q[2] != DIG_MAX_UNITS) begin
                        dig_d[2] = dig_q[2] + 1'b1;
                    end else begin
                        dig_d[2] = '0;
                        if (dig_q[3] != DIG_MAX_TENS) begin
                            dig_d[3] = dig_q[3] + 1'b1;
                        end else begin
                            dig_d[3] = '0;
                            wrap_d   = 1'b1;
                        end
                    end
                end
            end
        end

        if (lap_press) begin
            if (state_q == ST_RUN) begin
                if (!frozen_q) begin
                    snap_d   = dig_q;
                    frozen_d = 1'b1;
                end else begin
                    frozen_d = 1'b0;
                end
            end else if (state_q == ST_PAUSE) begin
                frozen_d = 1'b0;
            end
        end

        if (state_d == ST_IDLE) begin
            presc_d  = '0;
            dig_d    = '0;
            snap_d   = '0;
            frozen_d = 1'b0;
            wrap_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            tick_q   <= 1'b0;
            wrap_q   <= 1'b0;
            frozen_q <= 1'b0;
            dig_q    <= '0;
            snap_q   <= '0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            wrap_q   <= wrap_d;
            frozen_q <= frozen_d;
            dig_q    <= dig_d;
            snap_q   <= snap_d;
        end
    end

    assign disp0   = frozen_q ? snap_q[0] : dig_q[0];
    assign disp1   = frozen_q ? snap_q[1] : dig_q[1];
    assign disp2   = frozen_q ? snap_q[2] : dig_q[2];
    assign disp3   = frozen_q ? snap_q[3] : dig_q[3];
    assign running = (state_q == ST_RUN);
    assign frozen  = frozen_q;
    assign tick    = tick_q;
    assign wrap    = wrap_q;

endmodule
